// File: rtl/serial_load_controller.sv
// Serial program/data loader: assembles MSB-first 32-bit words from a strobed
// bit stream and writes them to sequential memory addresses while stalling the CPU.
module serial_load_controller #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic                  dataOnPin,
    input  logic                  dataPin,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  cpu_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned CNT_W = $clog2(WORD_WIDTH);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

    state_t                state, state_next;
    logic                  strobe_s1, strobe_s2, strobe_d;
    logic                  data_s1, data_s2;
    logic                  rise;
    logic [WORD_WIDTH-2:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [ADDR_WIDTH-1:0] word_cnt, word_cnt_next, word_inc;
    logic [ADDR_WIDTH-1:0] num_q, num_next;
    logic [TMR_W-1:0]      timer, timer_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [WORD_WIDTH-1:0] data_next;
    logic                  we_next, done_next, error_next, busy_next;

    assign rise     = strobe_s2 & ~strobe_d;
    assign word_inc = word_cnt + ADDR_WIDTH'(1);

    // Two-flop synchronisers for the host pins plus the edge-detect delay stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_d  <= 1'b0;
            data_s1   <= 1'b0;
            data_s2   <= 1'b0;
        end else begin
            strobe_s1 <= dataOnPin;
            strobe_s2 <= strobe_s1;
            strobe_d  <= strobe_s2;
            data_s1   <= dataPin;
            data_s2   <= data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            num_q     <= '0;
            timer     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            mem_data  <= '0;
            busy      <= 1'b0;
            cpu_stall <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            word_cnt  <= word_cnt_next;
            num_q     <= num_next;
            timer     <= timer_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_data  <= data_next;
            busy      <= busy_next;
            cpu_stall <= busy_next;
            done      <= done_next;
            error     <= error_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        word_cnt_next = word_cnt;
        num_next      = num_q;
        timer_next    = '0;
        addr_next     = mem_addr;
        data_next     = mem_data;
        we_next       = 1'b0;
        done_next     = done;
        error_next    = error;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    num_next      = num_words;
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                    addr_next     = ADDR_WIDTH'(BASE_ADDR);
                    bit_cnt_next  = '0;
                    word_cnt_next = '0;
                    shift_next    = '0;
                    if (num_words == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RECEIVE;
                    end
                end
            end
            RECEIVE: begin
                if (rise) begin
                    shift_next   = {shift_reg[WORD_WIDTH-3:0], data_s2};
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WORD_WIDTH - 1)) begin
                        data_next  = {shift_reg, data_s2};
                        we_next    = 1'b1;
                        state_next = WRITE;
                    end
                end else if (bit_cnt != '0) begin
                    // Host stalled mid-word: abort without writing the partial word.
                    if (timer == TMR_W'(TIMEOUT - 1)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        error_next = 1'b1;
                    end else begin
                        timer_next = timer + TMR_W'(1);
                    end
                end
            end
            WRITE: begin
                if (rise) begin
                    shift_next   = {shift_reg[WORD_WIDTH-3:0], data_s2};
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
                addr_next     = mem_addr + ADDR_WIDTH'(1);
                word_cnt_next = word_inc;
                if (word_inc == num_q) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = RECEIVE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == RECEIVE) || (state_next == WRITE);
    end
endmodule

// File: tb/tb_serial_load_controller.sv
// Bench for serial_load_controller: two instances (base 0 and base 4095) share
// the host stimulus; expected writes come from a per-load word list.
module tb_serial_load_controller;
    localparam int unsigned AW = 12;
    localparam int unsigned WW = 32;
    localparam int unsigned TO = 4096;
    localparam int unsigned BASE_B = 4095;

    logic          clk = 1'b0;
    logic          reset, start, dataOnPin, dataPin;
    logic [AW-1:0] num_words;

    logic          a_we, a_stall, a_busy, a_done, a_error;
    logic [AW-1:0] a_addr;
    logic [WW-1:0] a_data;
    logic          b_we, b_stall, b_busy, b_done, b_error;
    logic [AW-1:0] b_addr;
    logic [WW-1:0] b_data;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] qa_addr[$], qb_addr[$];
    logic [WW-1:0] qa_data[$], qb_data[$];

    always #5 clk = ~clk;

    serial_load_controller #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BASE_ADDR(0), .TIMEOUT(TO)) u_a (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .dataOnPin(dataOnPin), .dataPin(dataPin),
        .mem_we(a_we), .mem_addr(a_addr), .mem_data(a_data),
        .cpu_stall(a_stall), .busy(a_busy), .done(a_done), .error(a_error));

    serial_load_controller #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BASE_ADDR(BASE_B), .TIMEOUT(TO)) u_b (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .dataOnPin(dataOnPin), .dataPin(dataPin),
        .mem_we(b_we), .mem_addr(b_addr), .mem_data(b_data),
        .cpu_stall(b_stall), .busy(b_busy), .done(b_done), .error(b_error));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write k of the current load, for both base addresses.
    task automatic expect_word(input int k, input logic [WW-1:0] w);
        qa_addr.push_back(AW'(k));
        qb_addr.push_back(AW'(BASE_B + k));
        qa_data.push_back(w);
        qb_data.push_back(w);
    endtask

    // Every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (a_we) begin
            if (qa_data.size() == 0) chk("a_unexpected_we", a_we, 1'b0);
            else begin
                chk("a_addr", 64'(a_addr), 64'(qa_addr.pop_front()));
                chk("a_data", 64'(a_data), 64'(qa_data.pop_front()));
            end
        end
        if (b_we) begin
            if (qb_data.size() == 0) chk("b_unexpected_we", b_we, 1'b0);
            else begin
                chk("b_addr", 64'(b_addr), 64'(qb_addr.pop_front()));
                chk("b_data", 64'(b_data), 64'(qb_data.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b, input bit fast);
        dataPin   = b;
        dataOnPin = 1'b1;
        repeat (fast ? 3 : $urandom_range(3, 6)) @(negedge clk);
        dataOnPin = 1'b0;
        repeat (fast ? 3 : $urandom_range(3, 6)) @(negedge clk);
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit fast);
        for (int i = WW - 1; i >= 0; i--) send_bit(w[i], fast);
    endtask

    task automatic do_start(input int n);
        num_words = AW'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(a_done && b_done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_a"}, a_done, 1'b1);
        chk({tag, "_done_b"}, b_done, 1'b1);
    endtask

    task automatic check_finished(input string tag, input logic exp_err);
        chk({tag, "_err_a"}, a_error, exp_err);
        chk({tag, "_err_b"}, b_error, exp_err);
        chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
        chk({tag, "_stall"}, {a_stall, b_stall}, 2'b00);
        chk({tag, "_pending"}, 64'(qa_data.size() + qb_data.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_we"}, {a_we, b_we}, 2'b00);
        chk({tag, "_addr_a"}, 64'(a_addr), 64'd0);
        chk({tag, "_addr_b"}, 64'(b_addr), 64'(BASE_B));
        chk({tag, "_data"}, {a_data, b_data}, 64'd0);
        chk({tag, "_flags"}, {a_busy, a_stall, a_done, a_error, b_busy, b_stall, b_done, b_error}, 8'h00);
    endtask

    task automatic load(input string tag, input int n, input bit fast);
        logic [WW-1:0] w;
        do_start(n);
        chk({tag, "_busy"}, {a_busy, a_stall, b_busy, b_stall}, 4'hF);
        chk({tag, "_cleared"}, {a_done, a_error, b_done, b_error}, 4'h0);
        for (int k = 0; k < n; k++) begin
            w = $urandom();
            expect_word(k, w);
            send_word(w, fast);
        end
        wait_done(tag);
        check_finished(tag, 1'b0);
    endtask

    initial begin
        logic [WW-1:0] w;
        bit busy_seen;
        reset = 1'b1; start = 1'b0; dataOnPin = 1'b0; dataPin = 1'b0; num_words = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Directed two-word load, with a start pulse mid-load that must be ignored.
        do_start(2);
        chk("dir_busy", {a_busy, a_stall, b_busy, b_stall}, 4'hF);
        expect_word(0, 32'hDEADBEEF);
        expect_word(1, 32'h12345678);
        send_word(32'hDEADBEEF, 1'b0);
        do_start(0);
        chk("start_while_busy", {a_busy, b_busy, a_done, b_done}, 4'b1100);
        send_word(32'h12345678, 1'b0);
        wait_done("dir");
        check_finished("dir", 1'b0);

        // Zero-word load: straight to done with no writes and no busy.
        busy_seen = 1'b0;
        do_start(0);
        for (int i = 0; i < 5; i++) begin
            busy_seen |= a_busy | b_busy;
            @(negedge clk);
        end
        chk("zero_busy_seen", 64'(busy_seen), 64'd0);
        chk("zero_done", {a_done, b_done}, 2'b11);
        check_finished("zero", 1'b0);

        // Back-to-back words at minimum strobe spacing across the word boundary.
        do_start(2);
        expect_word(0, 32'hA5A5A5A5);
        expect_word(1, 32'h0000FFFF);
        send_word(32'hA5A5A5A5, 1'b1);
        send_word(32'h0000FFFF, 1'b1);
        wait_done("fast");
        check_finished("fast", 1'b0);

        for (int r = 0; r < 3; r++) load($sformatf("rand%0d", r), $urandom_range(1, 4), 1'b0);

        // Timeout after 10 bits: no write, error and done set, cleared by next start.
        do_start(3);
        w = $urandom();
        for (int i = WW - 1; i >= WW - 10; i--) send_bit(w[i], 1'b0);
        repeat (TO - 20) @(negedge clk);
        chk("to_early", {a_done, a_error, b_done, b_error}, 4'h0);
        wait_done("to");
        check_finished("to", 1'b1);
        load("after_to", 1, 1'b0);

        // Reset during the third word of a load.
        do_start(4);
        for (int k = 0; k < 2; k++) begin
            w = $urandom();
            expect_word(k, w);
            send_word(w, 1'b0);
        end
        w = $urandom();
        for (int i = WW - 1; i >= WW - 20; i--) send_bit(w[i], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        chk("midreset_pending", 64'(qa_data.size() + qb_data.size()), 64'd0);
        @(negedge clk);
        load("post_reset", 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
